// File: rtl/core_param_pkg.sv
// Shared definitions for the parametrised accumulator core: opcodes, FSM states, field helpers.
// Optional register file is enabled by defining CORE_PARAM_REGFILE_EN.
package core_param_pkg;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  // The opcode occupies the top three bits; an illegal REG_AW pushes it out of range at elaboration.
  function automatic int opLsb(input int dataW, input int regAw);
    return (dataW - 3 >= regAw) ? dataW - 3 : regAw;
  endfunction

  function automatic logic usesOperand(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
           (op == OP_LDA) || (op == OP_STO);
  endfunction

endpackage

// File: rtl/core_param_alu.sv
// Combinational accumulator ALU: produces the next accumulator value for a given opcode.
module core_param_alu #(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_operand,
  output logic [DATA_W-1:0] o_result
);
  import core_param_pkg::*;

  // ADD wraps modulo 2^DATA_W; non-arithmetic opcodes leave the accumulator untouched.
  always_comb begin
    o_result = i_acc;
    case (i_op)
      OP_ADD:  o_result = i_acc + i_operand;
      OP_AND:  o_result = i_acc & i_operand;
      OP_XOR:  o_result = i_acc ^ i_operand;
      OP_LDA:  o_result = i_operand;
      default: o_result = i_acc;
    endcase
  end

endmodule

// File: rtl/core_param.sv
// Parametrised multi-cycle accumulator core with a req/ack unified memory port and resumable halt.
// Define CORE_PARAM_REGFILE_EN to add the internal register file R1..R(2^REG_AW-1).
module core_param #(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 8,
  parameter int                REG_AW = 5,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] acc_dbg
);
  import core_param_pkg::*;

  localparam int OP_LSB = opLsb(DATA_W, REG_AW);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_irAddr;
  logic [ADDR_W-1:0] w_rdAddr;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_operand;
  logic [DATA_W-1:0] w_aluResult;
  logic [2:0]        r_irOp;
  logic              w_regForm;

  if (ADDR_W <= DATA_W) begin : gAddrNarrow
    assign w_rdAddr = mem_rdata[ADDR_W-1:0];
  end else begin : gAddrWide
    assign w_rdAddr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
  end

`ifdef CORE_PARAM_REGFILE_EN
  localparam int NUM_REGS = 2 ** REG_AW;

  logic [REG_AW-1:0] r_irReg;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // A nonzero reg field turns a memory-operand instruction into a single-cycle register access.
  assign w_regForm = (r_irReg != '0) && usesOperand(r_irOp);
  assign w_operand = w_regForm ? r_regs[r_irReg] : mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irReg <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == ST_FETCH0 && mem_ack) r_irReg <= mem_rdata[REG_AW-1:0];
      if (r_state == ST_EXEC && w_regForm && r_irOp == OP_STO) r_regs[r_irReg] <= r_acc;
    end
  end
`else
  assign w_regForm = 1'b0;
  assign w_operand = mem_rdata;
`endif

  core_param_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op      (r_irOp),
    .i_acc     (r_acc),
    .i_operand (w_operand),
    .o_result  (w_aluResult)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH0;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FETCH0: if (mem_ack) w_nextState = ST_FETCH1;
      ST_FETCH1: if (mem_ack) w_nextState = ST_DECODE;
      ST_DECODE: begin
        case (r_irOp)
          OP_HLT:         w_nextState = ST_HALT;
          OP_SKZ, OP_JMP: w_nextState = ST_FETCH0;
          default:        w_nextState = ST_EXEC;
        endcase
      end
      ST_EXEC:   if (w_regForm || mem_ack) w_nextState = ST_FETCH0;
      ST_HALT:   if (go) w_nextState = ST_FETCH0;
      default:   w_nextState = ST_FETCH0;
    endcase
  end

  // Port outputs depend only on registered state (and rst, which abandons any access).
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = r_pc;
    halted   = 1'b0;
    case (r_state)
      ST_FETCH0, ST_FETCH1: mem_req = !rst;
      ST_EXEC: begin
        mem_req  = !rst && !w_regForm;
        mem_we   = (r_irOp == OP_STO) && !w_regForm;
        mem_addr = r_irAddr;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RST_PC;
      r_acc    <= '0;
      r_irOp   <= '0;
      r_irAddr <= '0;
    end else begin
      case (r_state)
        ST_FETCH0: if (mem_ack) begin
          r_irOp <= mem_rdata[OP_LSB +: 3];
          r_pc   <= r_pc + ADDR_W'(1);
        end
        ST_FETCH1: if (mem_ack) begin
          r_irAddr <= w_rdAddr;
          r_pc     <= r_pc + ADDR_W'(1);
        end
        ST_DECODE: begin
          if (r_irOp == OP_SKZ && r_acc == '0) r_pc <= r_pc + ADDR_W'(2);
          else if (r_irOp == OP_JMP)           r_pc <= r_irAddr;
        end
        ST_EXEC: if ((w_regForm || mem_ack) && r_irOp != OP_STO) r_acc <= w_aluResult;
        default: ;
      endcase
    end
  end

  assign mem_wdata = r_acc;
  assign pc_dbg    = r_pc;
  assign acc_dbg   = r_acc;

endmodule

// File: doc/core_param.md
Name: core_param

Overview:
- Parametrised multi-cycle accumulator CPU core; successor to the fixed 8-bit core.
- Generalised in data width, address width and register count.
- Adds a single unified memory port with a req/ack handshake (arbitrary wait states), a resumable halt, and debug outputs.
- Instantiated by the SoC top next to a unified RAM/ROM wrapper that answers the handshake.

Parameters:
DATA_W, 8, data/accumulator width; must be >= 8
ADDR_W, 8, memory address width; PC width
REG_AW, 5, register-select field width; must be <= DATA_W-3
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  resume from HALT state
mem_req  out  1  memory access request
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  ADDR_W  access address
mem_wdata  out  DATA_W  write data (accumulator)
mem_rdata  in  DATA_W  read data; valid when mem_ack=1
mem_ack  in  1  access completes this cycle
halted  out  1  core is in HALT state
pc_dbg  out  ADDR_W  current PC
acc_dbg  out  DATA_W  current accumulator

Behaviour:
- Instruction format: two words.
  - Word0 = {op[2:0] in DATA_W-1..DATA_W-3, reg field in the low REG_AW bits}; remaining bits are ignored.
  - Word1 = operand address; its low ADDR_W bits are used.
- Opcodes:
  - 000 HLT
  - 001 SKZ: if acc==0 then PC+=2
  - 010 ADD: acc+=M[a]
  - 011 AND: acc&=M[a]
  - 100 XOR: acc^=M[a]
  - 101 LDA: acc=M[a]
  - 110 STO: M[a]=acc
  - 111 JMP: PC=a
- Arithmetic: ADD is modulo 2^DATA_W; carry is discarded. PC increments and SKZ skips wrap modulo 2^ADDR_W.
- States: FETCH0, FETCH1, DECODE, EXEC, HALT.
  - FETCH0: req read at PC. On ack, IR.hi<=rdata, PC<=PC+1, go to FETCH1.
  - FETCH1: req read at PC. On ack, IR.addr<=rdata, PC<=PC+1, go to DECODE.
  - DECODE (1 cycle, no req):
    - HLT: go to HALT.
    - SKZ: conditional PC+=2, then FETCH0.
    - JMP: PC<=addr, then FETCH0.
    - Other opcodes: go to EXEC.
  - EXEC: req at IR.addr, we=1 only for STO. On ack, update acc (ADD/AND/XOR/LDA), then FETCH0.
  - HALT: halted=1, no req. When go=1, go to FETCH0 next cycle with PC unchanged. If go is held high, execution continues.
- Handshake:
  - mem_req/we/addr/wdata are decoded from registered state only; there is no combinational path from mem_ack.
  - Outputs stay stable while req=1 and ack=0.
  - An ack in the same cycle as the first req is legal (zero wait).
  - mem_ack while req=0 is ignored.
- Latency at zero wait: memory-operand instruction 4 cycles; HLT/SKZ/JMP 3 cycles.
- Reset, any state: next cycle PC=RST_PC, acc=0, IR=0, state=FETCH0, halted=0. mem_req=0 during any cycle with rst=1; an in-flight access is abandoned. The first req rises in the cycle after rst falls.
- Debug outputs: pc_dbg and acc_dbg are the registered values; acc_dbg changes the cycle after the EXEC ack.

Optional Feature:
- Macro CORE_PARAM_REGFILE_EN.
- Defined:
  - Internal register file R1..R(2^REG_AW-1), DATA_W wide, reset to 0.
  - If the reg field is nonzero, ADD/AND/XOR/LDA read Rn and STO writes Rn=acc. EXEC then completes in 1 cycle with no mem_req.
  - If the reg field is 0, the memory operand is used as normal. JMP/SKZ/HLT ignore the field.
- Not defined: the reg field is ignored, no register storage is synthesised, and all operands come from memory.

Decomposition:
- Package core_param_pkg: opcode localparams (OP_HLT..OP_JMP), state enum/encoding, and field-position functions derived from DATA_W/REG_AW.
- Sub-module core_param_alu: combinational op/acc/operand -> result.
- Register file is inlined under the macro; no separate module.

Test Plan:
- Reset/first fetch: rst high 3 cycles, then low -> mem_req=0 during reset; first req at addr 0x00 one cycle after release; halted=0; acc_dbg=0.
- Arithmetic program with ack every cycle: LDA 0x80 (M=0xF0), ADD 0x81 (M=0x20) -> acc=0x10 (carry dropped); then STO 0x82 -> write req addr 0x82 data 0x10. Each instruction 4 cycles.
- Wait states: ack delayed 3 cycles on each access -> req/addr/we held stable; the same program gives the same results with 4x the memory-cycle count.
- Control flow: acc=0, SKZ -> next fetch at PC+4. acc=0x01, SKZ -> no skip. JMP 0xFE at wrap region -> fetch at 0xFE, 0xFF, then 0x00.
- HLT/resume: HLT -> halted=1, no req for 10 cycles. Pulse go -> fetch resumes at the address after HLT. Reset asserted mid-EXEC with ack pending -> req drops; restart at RST_PC.
- CORE_PARAM_REGFILE_EN: LDA M=0x5A, STO reg=3, LDA M=0x00, LDA reg=3 -> acc=0x5A. No mem_req in the reg-form EXEC cycles.
